// File: rtl/uart_prog_loader_if.sv
// Upgrade-port bundle: UART rx line in, instruction-memory write bus and status out.
interface uart_prog_loader_if;
  logic        rx;
  logic        upg_wen_o;
  logic [13:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        frame_err_o;

  modport master (
    input  rx,
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, frame_err_o
  );

  modport slave (
    output rx,
    input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, frame_err_o
  );
endinterface

// File: rtl/uart_prog_loader.sv
// 8N1 UART receiver feeding a loader that turns a counted little-endian word stream
// into instruction-memory writes, then raises a sticky done flag.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input logic                 upg_clk_i,
  input logic                 upg_rst_i,
  uart_prog_loader_if.master  bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
  typedef enum logic [1:0] {LCnt0, LCnt1, LData, LDone} ld_state_e;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  logic rx_meta_q, rxs_q;

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rxs_q     <= rx_meta_q;
    end
  end

  rx_state_e       r_state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic [7:0]      byte_q;
  logic            byte_vld_q;
  logic            frame_err_q;

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      r_state_q   <= RIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      unique case (r_state_q)
        RIdle: begin
          cnt_q <= '0;
          if (!rxs_q) r_state_q <= RStart;
        end
        RStart: begin
          if (cnt_q == HalfCnt) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            r_state_q <= rxs_q ? RIdle : RData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RData: begin
          if (cnt_q == LastCnt) begin
            cnt_q     <= '0;
            shreg_q   <= {rxs_q, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) r_state_q <= RStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RStop: begin
          // Returning at mid stop bit leaves half a bit of slack for back-to-back frames.
          if (cnt_q == LastCnt) begin
            cnt_q     <= '0;
            r_state_q <= RIdle;
            if (rxs_q) begin
              byte_q     <= shreg_q;
              byte_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  ld_state_e   l_state_q;
  logic [7:0]  cnt_lo_q;
  logic [13:0] n_words_q;
  logic [13:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_buf_q;
  logic        wen_q;
  logic [13:0] adr_q;
  logic [31:0] dat_q;
  logic        done_q;
  logic [13:0] n_rx;

  assign n_rx = {byte_q[5:0], cnt_lo_q};

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      l_state_q  <= LCnt0;
      cnt_lo_q   <= '0;
      n_words_q  <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      unique case (l_state_q)
        LCnt0: begin
          if (byte_vld_q) begin
            cnt_lo_q  <= byte_q;
            l_state_q <= LCnt1;
          end
        end
        LCnt1: begin
          if (byte_vld_q) begin
            n_words_q  <= n_rx;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            if (n_rx == 14'd0) begin
              l_state_q <= LDone;
              done_q    <= 1'b1;
            end else begin
              l_state_q <= LData;
            end
          end
        end
        LData: begin
          if (byte_vld_q) begin
            // Shift right so the first three bytes land little-endian in word_buf_q.
            word_buf_q <= {byte_q, word_buf_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              wen_q      <= 1'b1;
              adr_q      <= word_idx_q;
              dat_q      <= {byte_q, word_buf_q};
              word_idx_q <= word_idx_q + 14'd1;
              if (word_idx_q == n_words_q - 14'd1) l_state_q <= LDone;
            end
          end
        end
        LDone:   done_q <= 1'b1;
        default: l_state_q <= LCnt0;
      endcase
    end
  end

  assign bus.upg_wen_o   = wen_q;
  assign bus.upg_adr_o   = adr_q;
  assign bus.upg_dat_o   = dat_q;
  assign bus.upg_done_o  = done_q;
  assign bus.frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at 16 clocks per bit; logs strobes and checks
// address, data, counts and cycle-exact done/strobe latency per scenario.
module tb_uart_prog_loader;
  localparam int unsigned Cpb = 16;
  // Start edge to loader output: 2 sync + 1 idle detect + 8 start + 9*16 sample + 1 register.
  localparam int ExpLat = 156;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_prog_loader_if bus ();

  uart_prog_loader #(.CLKS_PER_BIT(Cpb)) dut (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [13:0] adr_q[$];
  logic [31:0] dat_q[$];
  int          wen_cyc_q[$];
  int          done_cyc;
  int          overlap;
  int          last_start;
  logic        done_prev;

  always @(negedge clk) begin
    if (bus.upg_wen_o === 1'b1) begin
      adr_q.push_back(bus.upg_adr_o);
      dat_q.push_back(bus.upg_dat_o);
      wen_cyc_q.push_back(cyc);
    end
    if (bus.upg_wen_o === 1'b1 && bus.upg_done_o === 1'b1) overlap++;
    if (bus.upg_done_o === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = bus.upg_done_o;
  end

  task automatic idle_bits(input int n);
    repeat (n * Cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    last_start = cyc;
    idle_bits(1);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      idle_bits(1);
    end
    bus.rx = stop;
    idle_bits(1);
    bus.rx = 1'b1;
    if (!stop) idle_bits(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    adr_q.delete();
    dat_q.delete();
    wen_cyc_q.delete();
    done_cyc = -1;
    overlap = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o, bus.upg_done_o, bus.frame_err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wen=%b adr=%h dat=%h done=%b ferr=%b, want all 0",
               bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o, bus.upg_done_o, bus.frame_err_o);
    end
    do_reset();
  endtask

  task automatic test_normal();
    logic [7:0] seq [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (wen_cyc_q.size() !== 2) begin
      n_fail++; $display("FAIL normal_count: got %0d strobes, want 2", wen_cyc_q.size());
    end
    n_checks++;
    if (adr_q[0] !== 14'd0 || dat_q[0] !== 32'h12345678) begin
      n_fail++; $display("FAIL normal_w0: got adr=%h dat=%h, want 0 12345678", adr_q[0], dat_q[0]);
    end
    n_checks++;
    if (adr_q[1] !== 14'd1 || dat_q[1] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL normal_w1: got adr=%h dat=%h, want 1 deadbeef", adr_q[1], dat_q[1]);
    end
    n_checks++;
    if (wen_cyc_q[1] - last_start !== ExpLat) begin
      n_fail++;
      $display("FAIL normal_wen_lat: got %0d cycles, want %0d", wen_cyc_q[1] - last_start, ExpLat);
    end
    n_checks++;
    if (done_cyc !== wen_cyc_q[1] + 1 || bus.upg_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL normal_done: got done_cyc=%0d done=%b, want cyc %0d done=1",
               done_cyc, bus.upg_done_o, wen_cyc_q[1] + 1);
    end
    n_checks++;
    if (bus.frame_err_o !== 1'b0 || overlap !== 0) begin
      n_fail++;
      $display("FAIL normal_ferr_overlap: got ferr=%b overlap=%0d, want 0 0", bus.frame_err_o, overlap);
    end
  endtask

  task automatic test_empty();
    logic [7:0] post [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cyc - last_start !== ExpLat || bus.upg_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_done: got lat=%0d done=%b, want %0d 1", done_cyc - last_start,
               bus.upg_done_o, ExpLat);
    end
    foreach (post[i]) send_byte(post[i], 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (wen_cyc_q.size() !== 0 || bus.upg_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_post: got strobes=%0d done=%b, want 0 1", wen_cyc_q.size(), bus.upg_done_o);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    idle_bits(2);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 12; i++) send_byte(8'(i + 1), 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (wen_cyc_q.size() !== 3 || adr_q[2] !== 14'd2 || dat_q[2] !== 32'h0C0B0A09) begin
      n_fail++;
      $display("FAIL glitch_words: got strobes=%0d adr2=%h dat2=%h, want 3 2 0c0b0a09",
               wen_cyc_q.size(), adr_q[2], dat_q[2]);
    end
    n_checks++;
    if (bus.upg_done_o !== 1'b1 || bus.frame_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_status: got done=%b ferr=%b, want 1 0", bus.upg_done_o, bus.frame_err_o);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] seq [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b0);
    n_checks++;
    if (bus.frame_err_o !== 1'b1 || wen_cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL ferr_set: got ferr=%b strobes=%0d, want 1 0", bus.frame_err_o, wen_cyc_q.size());
    end
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (wen_cyc_q.size() !== 1 || adr_q[0] !== 14'd0 || dat_q[0] !== 32'hDDCCBBAA
        || bus.upg_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_word: got strobes=%0d adr=%h dat=%h done=%b, want 1 0 ddccbbaa 1",
               wen_cyc_q.size(), adr_q[0], dat_q[0], bus.upg_done_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pre [4] = '{8'h01, 8'h00, 8'h78, 8'h56};
    logic [7:0] seq [6] = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    do_reset();
    foreach (pre[i]) send_byte(pre[i], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o, bus.upg_done_o, bus.frame_err_o} !== '0
        || wen_cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got wen=%b adr=%h dat=%h done=%b strobes=%0d, want all 0",
               bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o, bus.upg_done_o, wen_cyc_q.size());
    end
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (wen_cyc_q.size() !== 1 || adr_q[0] !== 14'd0 || dat_q[0] !== 32'h11223344
        || bus.upg_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_word: got strobes=%0d adr=%h dat=%h done=%b, want 1 0 11223344 1",
               wen_cyc_q.size(), adr_q[0], dat_q[0], bus.upg_done_o);
    end
  endtask

  task automatic test_count_mask();
    logic [7:0] seq [6] = '{8'h01, 8'hC0, 8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (wen_cyc_q.size() !== 1 || dat_q[0] !== 32'h04030201 || done_cyc !== wen_cyc_q[0] + 1) begin
      n_fail++;
      $display("FAIL mask_word: got strobes=%0d dat=%h done_cyc=%0d, want 1 04030201 %0d",
               wen_cyc_q.size(), dat_q[0], done_cyc, wen_cyc_q[0] + 1);
    end
    n_checks++;
    if (bus.upg_done_o !== 1'b1 || overlap !== 0) begin
      n_fail++;
      $display("FAIL mask_done: got done=%b overlap=%0d, want 1 0", bus.upg_done_o, overlap);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    done_cyc = -1;
    overlap = 0;
    last_start = 0;
    test_reset();
    test_normal();
    test_empty();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_count_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

UART program loader that drives the instruction-memory upgrade port. It receives a serial 8N1 byte stream from the host, assembles little-endian 32-bit words, and issues one write per word on the upg_wen/upg_adr/upg_dat bus. When the announced word count is complete it raises upg_done, which hands instruction memory back to the CPU.

## Interface
- CLKS_PER_BIT, default 868: upg_clk_i cycles per UART bit. The default gives 115200 baud at 100 MHz. Legal values are 4 or more.
- upg_clk_i  input  1: clock; every register is rising-edge.
- upg_rst_i  input  1: reset. Asynchronous, active-high.
- rx  input  1: UART serial line, idle high, asynchronous to upg_clk_i.
- upg_wen_o  output  1: one-cycle write strobe.
- upg_adr_o  output  14: word address of the current write.
- upg_dat_o  output  32: write data.
- upg_done_o  output  1: load complete; sticky until reset.
- frame_err_o  output  1: sticky flag, set on any stop-bit error.

## Operation
- **rx synchroniser:** two-flop synchroniser. All receive logic uses the synchronised signal rxs.
- **Receiver states:** R_IDLE, R_START, R_DATA, R_STOP. A bit counter cnt counts 0..CLKS_PER_BIT-1.
  - R_IDLE: when rxs=0, go to R_START with cnt=0.
  - R_START: at cnt=CLKS_PER_BIT/2-1 (mid start bit), sample rxs. If 1, treat it as a glitch and return to R_IDLE. If 0, go to R_DATA with cnt=0.
  - R_DATA: sample rxs every CLKS_PER_BIT cycles (mid-bit), 8 bits, LSB first. Then go to R_STOP.
  - R_STOP: at mid stop bit, if rxs=1, pulse byte_vld for one cycle with the byte. If rxs=0, set frame_err_o and drop the byte. Either way return to R_IDLE. Because it returns at mid stop bit, back-to-back frames are accepted.
- **Loader states:** L_CNT0, L_CNT1, L_DATA, L_DONE.
  - L_CNT0: the first valid byte is cnt_lo; go to L_CNT1.
  - L_CNT1: the next valid byte is cnt_hi. The word count is N = {cnt_hi[5:0], cnt_lo}, range 0..16383; cnt_hi[7:6] are ignored. If N=0, go to L_DONE. Otherwise go to L_DATA with word index 0 and byte index 0.
  - L_DATA: bytes fill the word buffer little-endian. Byte 0 goes to [7:0], byte 3 to [31:24].
    - On the 4th byte: upg_wen_o=1 for one cycle, upg_adr_o = word index, upg_dat_o = the assembled word. Then the word index increments and the byte index returns to 0.
    - After write number N, go to L_DONE.
  - L_DONE: upg_done_o=1. All further bytes are ignored; the receiver keeps running.
- A dropped (framing-error) byte does not advance the loader. The host is responsible for retransmission or reset.
- upg_adr_o and upg_dat_o hold their last values between strobes. They are meaningful only while upg_wen_o=1.

## Timing
- **Reset values:** upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, frame_err_o=0. Receiver in R_IDLE, loader in L_CNT0, all counters and the word buffer at 0.
- **Reset mid-operation:** asserting upg_rst_i at any point aborts the current frame and the partial word. No strobe is produced after reset asserts. The next load starts at L_CNT0 and address 0.
- **Start detection:** the falling edge on rx reaches rxs after 2 clock cycles.
- **Byte latency:** byte_vld asserts at the mid stop-bit sample, 9.5 bit times after the start edge plus 2 synchroniser cycles.
- **Write strobe:** upg_wen_o asserts exactly 1 cycle after byte_vld of the 4th byte of a word. upg_adr_o and upg_dat_o are valid in the same cycle.
- **Done:** upg_done_o asserts 1 cycle after the final upg_wen_o. For N=0 it asserts 1 cycle after byte_vld of cnt_hi. It is never high in the same cycle as upg_wen_o.
- **Rate limit:** at most one byte_vld per 9 bit times, so strobes are always separated by at least 36·CLKS_PER_BIT cycles.
- **Counter width:** cnt width is clog2(CLKS_PER_BIT). The word index is 14 bits and cannot wrap, since N ≤ 16383.

## Test plan
- **Normal load** (CLKS_PER_BIT=16). Send 02 00 78 56 34 12 EF BE AD DE. Expect:
  - upg_wen_o pulse with adr=0, dat=0x12345678;
  - then a pulse with adr=1, dat=0xDEADBEEF;
  - upg_done_o=1 one cycle later;
  - exactly 2 strobes total, frame_err_o=0.
- **Empty load and post-done traffic.** Send 00 00 -> upg_done_o=1 one cycle after the 2nd byte, with no strobes. Then send 11 22 33 44 -> no strobes and done stays 1.
- **Glitch rejection.** Drive rx low for 5 cycles (less than half a bit), then a valid byte 0x03 -> the glitch is ignored and the loader sees only 0x03 (cnt_lo=3).
- **Framing error.** Send 01 00, then a frame carrying 0xAA with stop bit 0, then AA BB CC DD. Expect:
  - frame_err_o=1 after the bad frame;
  - the dropped byte is not counted;
  - one write with adr=0, dat=0xDDCCBBAA, then done.
- **Reset mid-word.** Send 01 00 78 56, then pulse upg_rst_i. Expect all outputs back to 0. Then send 01 00 44 33 22 11 -> a single write with adr=0, dat=0x11223344, then done.
- **Count masking.** Send cnt bytes 01 C0 -> N=1 (bits [7:6] ignored). Then send 4 data bytes -> exactly one strobe, then done.
